// File: rtl/sc_pnode_decoder.sv
// sc_pnode_decoder: sequential min-sum successive-cancellation polar decoder for one block of N = 2**N_LOG LLRs
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   llr_in     N sign-magnitude channel LLRs, y_i = llr_in[(i+1)*Q-1 -: Q]
//   frozen_in  bit i set forces u_i = 0
//   in_valid   llr_in/frozen_in valid
//   in_ready   decoder idle, a block can be accepted
//   u_out      decoded message, bit i = u_i
//   x_out      re-encoded codeword, bit i = x_i
//   out_valid  u_out/x_out valid until out_ready
//   out_ready  downstream accepts the result
//   busy       decoding or holding a result
module sc_pnode_decoder #(
    parameter int N_LOG = 2,
    parameter int Q     = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [(1<<N_LOG)*Q-1:0]     llr_in,
    input  logic [(1<<N_LOG)-1:0]       frozen_in,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [(1<<N_LOG)-1:0]       u_out,
    output logic [(1<<N_LOG)-1:0]       x_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy
);
    localparam int N  = 1 << N_LOG;
    localparam int DW = $clog2(N_LOG + 1);
    localparam int SW = N_LOG + 1;
    localparam logic [SW-1:0] LAST = SW'(2 * N - 3);
    localparam logic [DW-1:0] LEAF = DW'(N_LOG);
    localparam logic [Q:0] MAXV = (Q + 1)'(2 ** (Q - 1) - 1);
    localparam logic [1:0] S_IDLE = 2'd0, S_DECODE = 2'd1, S_DONE = 2'd2;

    logic [1:0]     state;
    // llr[d] holds the LLR vector of the current node at depth d (N>>d entries used)
    logic [Q-1:0]   llr [0:N_LOG][0:N-1];
    // psl[d] holds the partial sums of the finished left child at depth d
    logic [N-1:0]   psl [0:N_LOG];
    logic [N-1:0]   frz, u_r;
    logic [DW-1:0]  d;
    logic [N_LOG-1:0] k;
    logic [SW-1:0]  step;

    logic [Q-1:0]   child [0:N-1];
    logic [N_LOG-1:0] half;
    logic [DW-1:0]  dp, lvl;
    logic [N_LOG-1:0] idx;
    logic [N-1:0]   x_c, low;
    logic           bit_u, climb;
    int             ms;

    function automatic logic [Q-1:0] f_op(input logic [Q-1:0] a, input logic [Q-1:0] b);
        logic [Q-2:0] m;
        m = (a[Q-2:0] < b[Q-2:0]) ? a[Q-2:0] : b[Q-2:0];
        return {(a[Q-1] ^ b[Q-1]) & (m != '0), m};
    endfunction

    function automatic logic [Q-1:0] g_op(input logic [Q-1:0] a, input logic [Q-1:0] b, input logic s);
        logic signed [Q:0] va, vb, r;
        logic [Q:0]   mag;
        logic [Q-2:0] sat;
        va  = $signed({2'b00, a[Q-2:0]});
        va  = (a[Q-1] ^ s) ? -va : va;
        vb  = $signed({2'b00, b[Q-2:0]});
        vb  = b[Q-1] ? -vb : vb;
        r   = vb + va;
        mag = r[Q] ? -r : r;
        sat = (mag > MAXV) ? MAXV[Q-2:0] : mag[Q-2:0];
        return {r[Q], sat};
    endfunction

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    always_comb begin
        dp   = d - DW'(1);
        half = N_LOG'(N >> d);
        for (int j = 0; j < N; j++) begin
            child[j] = '0;
            if (N_LOG'(j) < half)
                child[j] = k[0] ? g_op(llr[dp][N_LOG'(j)], llr[dp][N_LOG'(j) + half], psl[d][j])
                                : f_op(llr[dp][N_LOG'(j)], llr[dp][N_LOG'(j) + half]);
        end
        bit_u = ~frz[k] & child[0][Q-1];
        // Leaf: fold partial sums upward while the finished node is a right child
        x_c   = N'(bit_u);
        lvl   = d;
        idx   = k;
        climb = 1'b1;
        ms    = 0;
        low   = '0;
        for (int t = 0; t < N_LOG; t++) begin
            if (climb && idx[0]) begin
                ms  = N >> lvl;
                low = (N'(1) << ms) - N'(1);
                x_c = ((psl[lvl] ^ x_c) & low) | (x_c << ms);
                lvl = lvl - DW'(1);
                idx = idx >> 1;
            end else
                climb = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            d     <= '0;
            k     <= '0;
            step  <= '0;
            frz   <= '0;
            u_r   <= '0;
            u_out <= '0;
            x_out <= '0;
            for (int i = 0; i <= N_LOG; i++) begin
                psl[i] <= '0;
                for (int j = 0; j < N; j++)
                    llr[i][j] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    for (int j = 0; j < N; j++)
                        llr[0][j] <= llr_in[j*Q +: Q];
                    frz   <= frozen_in;
                    step  <= '0;
                    d     <= DW'(1);
                    k     <= '0;
                    u_r   <= '0;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    step <= step + SW'(1);
                    if (d != LEAF) begin
                        for (int j = 0; j < N; j++)
                            llr[d][j] <= child[j];
                        d <= d + DW'(1);
                        k <= k << 1;
                    end else begin
                        u_r[k] <= bit_u;
                        if (step == LAST) begin
                            u_out <= u_r | (N'(bit_u) << k);
                            x_out <= x_c;
                            state <= S_DONE;
                        end else begin
                            // Store the finished left subtree, continue with its right sibling
                            psl[lvl] <= x_c;
                            d        <= lvl;
                            k        <= idx + N_LOG'(1);
                        end
                    end
                end
                S_DONE: if (out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sc_pnode_decoder.sv
// tb_sc_pnode_decoder: directed and randomized checks of sc_pnode_decoder against a behavioural SC model
module tb_sc_pnode_decoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sm2i(input logic [7:0] v);
        return v[7] ? -int'(v[6:0]) : int'(v[6:0]);
    endfunction

    function automatic int clamp(input int v);
        return v > 127 ? 127 : (v < -127 ? -127 : v);
    endfunction

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    // Polar transform of the first m bits of v
    function automatic logic [15:0] enc(input logic [15:0] v, input int m);
        logic [15:0] r;
        r = v;
        for (int h = 1; h < m; h *= 2)
            for (int b = 0; b < m; b += 2 * h)
                for (int j = b; j < b + h; j++)
                    r[j] = r[j] ^ r[j+h];
        for (int j = m; j < 16; j++) r[j] = 1'b0;
        return r;
    endfunction

    // Each leaf LLR is recomputed from the channel along its root path; right-child
    // g inputs use the polar transform of the left sibling's decided bits.
    function automatic void sc_model(input int n, input logic [127:0] y, input logic [15:0] fr,
                                     output logic [15:0] u, output logic [15:0] x);
        int nn, m, k, mn;
        int cur [16];
        int nxt [16];
        logic [15:0] s;
        nn = 1 << n;
        u  = '0;
        for (int i = 0; i < nn; i++) begin
            for (int j = 0; j < 16; j++) cur[j] = (j < nn) ? sm2i(y[j*8 +: 8]) : 0;
            for (int d = 1; d <= n; d++) begin
                m = nn >> d;
                k = i >> (n - d);
                s = '0;
                if (k % 2 == 1) s = enc(u >> ((k - 1) * m), m);
                for (int j = 0; j < 16; j++) nxt[j] = 0;
                for (int j = 0; j < m; j++) begin
                    mn = iabs(cur[j]) < iabs(cur[j+m]) ? iabs(cur[j]) : iabs(cur[j+m]);
                    if (k % 2 == 1)
                        nxt[j] = clamp(cur[j+m] + (s[j] ? -cur[j] : cur[j]));
                    else
                        nxt[j] = ((cur[j] < 0) != (cur[j+m] < 0)) ? -mn : mn;
                end
                for (int j = 0; j < 16; j++) cur[j] = nxt[j];
            end
            u[i] = !fr[i] && (cur[0] < 0);
        end
        x = enc(u, nn);
    endfunction

    // Directed instance, N = 4
    logic        rst_n, d_iv, d_or, d_ir, d_ov, d_busy;
    logic [31:0] d_llr;
    logic [3:0]  d_fr, d_u, d_x;

    sc_pnode_decoder #(.N_LOG(2), .Q(8)) dut (
        .clk(clk), .rst_n(rst_n), .llr_in(d_llr), .frozen_in(d_fr), .in_valid(d_iv),
        .in_ready(d_ir), .u_out(d_u), .x_out(d_x), .out_valid(d_ov), .out_ready(d_or), .busy(d_busy)
    );

    localparam logic [31:0] Y1 = {8'h87, 8'h82, 8'h83, 8'h85};
    localparam logic [31:0] Y2 = {8'h64, 8'h64, 8'hE4, 8'hE4};
    localparam logic [31:0] Y3 = 32'h80808080;

    task automatic send(input string tag, input logic [31:0] y, input logic [3:0] fr);
        int cnt;
        d_llr = y;
        d_fr  = fr;
        d_iv  = 1'b1;
        cnt   = 0;
        while (!d_ir && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, "_ready"}, d_ir, 1);
        @(posedge clk); #1;
        d_iv = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!d_ov && lat < 50);
    endtask

    task automatic run_block(input string tag, input logic [31:0] y, input logic [3:0] fr,
                             input logic [3:0] eu, input logic [3:0] ex);
        int lat;
        send(tag, y, fr);
        wait_out(lat);
        check({tag, "_lat"}, lat, 6);
        check({tag, "_u"}, d_u, eu);
        check({tag, "_x"}, d_x, ex);
    endtask

    // Randomized instances, N_LOG = 1..3
    logic rst_r;
    initial begin
        rst_r = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_r = 1'b1;
    end

    for (genvar g = 0; g < 3; g++) begin : rnd
        localparam int NL = g + 1;
        localparam int NN = 1 << NL;
        logic iv, orr, ir, ov, bz, done;
        logic [NN*8-1:0] llr;
        logic [NN-1:0]   fr, u, x;

        sc_pnode_decoder #(.N_LOG(NL), .Q(8)) dut (
            .clk(clk), .rst_n(rst_r), .llr_in(llr), .frozen_in(fr), .in_valid(iv),
            .in_ready(ir), .u_out(u), .x_out(x), .out_valid(ov), .out_ready(orr), .busy(bz)
        );

        initial begin
            logic [15:0] eu, ex;
            int cnt, lat;
            done = 1'b0;
            iv   = 1'b0;
            orr  = 1'b1;
            llr  = '0;
            fr   = '0;
            repeat (5) @(posedge clk);
            #1;
            for (int b = 0; b < 1000; b++) begin
                for (int j = 0; j < NN; j++) llr[j*8 +: 8] = 8'($urandom);
                fr = NN'($urandom);
                sc_model(NL, 128'(llr), 16'(fr), eu, ex);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                iv  = 1'b1;
                cnt = 0;
                while (!ir && cnt < 100) begin
                    @(posedge clk); #1;
                    cnt++;
                end
                check("rnd_ready", ir, 1);
                @(posedge clk); #1;
                iv  = 1'b0;
                orr = 1'($urandom_range(0, 1));
                lat = 0;
                do begin
                    @(posedge clk); #1;
                    lat++;
                end while (!ov && lat < 100);
                check("rnd_lat", lat, 2 * NN - 2);
                check("rnd_u", 32'(u), 32'(eu[NN-1:0]));
                check("rnd_x", 32'(x), 32'(ex[NN-1:0]));
                if (!orr) begin
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge clk); #1;
                    end
                    check("rnd_hold_valid", ov, 1);
                    orr = 1'b1;
                end
                @(posedge clk); #1;
                check("rnd_handshake", ov, 0);
            end
            done = 1'b1;
        end
    end

    initial begin
        int lat, cnt;
        rst_n = 1'b0;
        d_iv  = 1'b0;
        d_or  = 1'b1;
        d_llr = '0;
        d_fr  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready_low", d_ir, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", d_ir, 1);
        check("rst_out_valid", d_ov, 0);
        check("rst_busy", d_busy, 0);
        check("rst_u", d_u, 0);
        check("rst_x", d_x, 0);

        run_block("t1", Y1, 4'b0011, 4'b1000, 4'b1111);
        @(posedge clk); #1;
        check("t1_hs_valid", d_ov, 0);
        check("t1_hs_ready", d_ir, 1);
        run_block("t2_sat", Y2, 4'b0000, 4'b0010, 4'b0011);
        @(posedge clk); #1;
        run_block("t3_negzero", Y3, 4'b0000, 4'b0000, 4'b0000);
        @(posedge clk); #1;

        d_or = 1'b0;
        run_block("bb1", Y1, 4'b0011, 4'b1000, 4'b1111);
        d_llr = Y2;
        d_fr  = 4'b0000;
        d_iv  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bb_hold_valid", d_ov, 1);
            check("bb_hold_ready", d_ir, 0);
            check("bb_hold_u", d_u, 4'b1000);
            check("bb_hold_x", d_x, 4'b1111);
        end
        d_or = 1'b1;
        @(posedge clk); #1;
        check("bb_release_valid", d_ov, 0);
        check("bb_release_ready", d_ir, 1);
        @(posedge clk); #1;
        check("bb_accept_busy", d_busy, 1);
        d_iv = 1'b0;
        wait_out(lat);
        check("bb2_lat", lat, 6);
        check("bb2_u", d_u, 4'b0010);
        check("bb2_x", d_x, 4'b0011);
        @(posedge clk); #1;

        send("mid_rst", Y1, 4'b0011);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", d_ov, 0);
        check("mid_rst_u", d_u, 0);
        check("mid_rst_x", d_x, 0);
        check("mid_rst_busy", d_busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_ready", d_ir, 1);
        run_block("post_rst", Y2, 4'b0000, 4'b0010, 4'b0011);
        @(posedge clk); #1;

        cnt = 0;
        while (!(rnd[0].done && rnd[1].done && rnd[2].done) && cnt < 60000) begin
            @(posedge clk);
            cnt++;
        end
        check("rnd_complete", rnd[0].done && rnd[1].done && rnd[2].done, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
